crossbar_2x2_scheduler: RTL and testbench

CROSSBAR_2X2_SCHEDULER -- requirements
Module: crossbar_2x2_scheduler

---
 rtl/crossbar_2x2_scheduler.sv | 126 ++++++++++++
 tb/tb_crossbar_2x2_scheduler.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/crossbar_2x2_scheduler.sv
// 2x2 crossbar scheduler: two 2-deep input FIFOs feed two registered outputs,
// with round-robin arbitration per output when both heads want the same one.
module crossbar_2x2_scheduler (
    input  logic       clk,
    input  logic       rst,
    input  logic       in1_valid,
    input  logic [3:0] in1_data,
    input  logic       in1_dest,
    output logic       in1_ready,
    input  logic       in2_valid,
    input  logic [3:0] in2_data,
    input  logic       in2_dest,
    output logic       in2_ready,
    output logic       out1_valid,
    output logic [3:0] out1_data,
    output logic       out1_src,
    input  logic       out1_ready,
    output logic       out2_valid,
    output logic [3:0] out2_data,
    output logic       out2_src,
    input  logic       out2_ready,
    output logic       control
);

    typedef struct packed {
        logic [3:0] data;
        logic       dest;
    } entry_t;

    entry_t     r_fifo [2][2];
    logic [1:0] r_cnt [2];
    logic       r_wr [2];
    logic       r_rd [2];

    logic       r_out_valid [2];
    logic [3:0] r_out_data [2];
    logic       r_out_src [2];
    logic       r_prio [2];
    logic       r_control;

    logic       w_in_valid [2];
    entry_t     w_in_entry [2];
    logic       w_in_ready [2];
    logic       w_out_ready [2];
    entry_t     w_head [2];
    logic       w_head_valid [2];
    logic       w_free [2];
    logic       w_elig [2];
    logic       w_same_dest;
    logic       w_push [2];
    logic       w_grant [2];

    always_comb begin
        w_in_valid[0]  = in1_valid;
        w_in_valid[1]  = in2_valid;
        w_in_entry[0]  = '{data: in1_data, dest: in1_dest};
        w_in_entry[1]  = '{data: in2_data, dest: in2_dest};
        w_out_ready[0] = out1_ready;
        w_out_ready[1] = out2_ready;
    end

    // Readiness looks only at the registered count, never at a same-cycle pop.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_in_ready[i]   = !rst && (r_cnt[i] < 2'd2);
            w_push[i]       = w_in_valid[i] && w_in_ready[i];
            w_head[i]       = r_fifo[i][r_rd[i]];
            w_head_valid[i] = (r_cnt[i] != 2'd0);
            w_free[i]       = !r_out_valid[i] || w_out_ready[i];
        end
        for (int i = 0; i < 2; i++) begin
            w_elig[i] = w_head_valid[i] && w_free[w_head[i].dest];
        end
        w_same_dest = (w_head[0].dest == w_head[1].dest);
        w_grant[0]  = w_elig[0] && !(w_elig[1] && w_same_dest && r_prio[w_head[0].dest]);
        w_grant[1]  = w_elig[1] && !(w_elig[0] && w_same_dest && !r_prio[w_head[1].dest]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: FIFO storage is left unreset; the counts and pointers alone mark it empty.
            for (int i = 0; i < 2; i++) begin
                r_cnt[i]       <= 2'd0;
                r_wr[i]        <= 1'b0;
                r_rd[i]        <= 1'b0;
                r_out_valid[i] <= 1'b0;
                r_out_data[i]  <= 4'd0;
                r_out_src[i]   <= 1'b0;
                r_prio[i]      <= 1'b0;
            end
            r_control <= 1'b0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (w_out_ready[n]) r_out_valid[n] <= 1'b0;
            end
            for (int i = 0; i < 2; i++) begin
                if (w_push[i]) begin
                    r_fifo[i][r_wr[i]] <= w_in_entry[i];
                    r_wr[i]            <= !r_wr[i];
                end
                if (w_grant[i]) begin
                    r_rd[i]                      <= !r_rd[i];
                    r_out_valid[w_head[i].dest]  <= 1'b1;
                    r_out_data[w_head[i].dest]   <= w_head[i].data;
                    r_out_src[w_head[i].dest]    <= 1'(i);
                    r_prio[w_head[i].dest]       <= (i == 0);
                end
                r_cnt[i] <= r_cnt[i] + 2'(w_push[i]) - 2'(w_grant[i]);
            end
            if (w_grant[0] || w_grant[1]) begin
                r_control <= !((w_grant[0] && !w_head[0].dest) || (w_grant[1] && w_head[1].dest));
            end
        end
    end

    assign in1_ready  = w_in_ready[0];
    assign in2_ready  = w_in_ready[1];
    assign out1_valid = r_out_valid[0];
    assign out1_data  = r_out_data[0];
    assign out1_src   = r_out_src[0];
    assign out2_valid = r_out_valid[1];
    assign out2_data  = r_out_data[1];
    assign out2_src   = r_out_src[1];
    assign control    = r_control;

endmodule

// File: tb/tb_crossbar_2x2_scheduler.sv
// Directed bench for crossbar_2x2_scheduler with a short random phase checked
// against a per-(source,destination) reference queue.
module tb_crossbar_2x2_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in1_valid = 1'b0, in2_valid = 1'b0;
    logic [3:0] in1_data = 4'd0, in2_data = 4'd0;
    logic       in1_dest = 1'b0, in2_dest = 1'b0;
    logic       in1_ready, in2_ready;
    logic       out1_valid, out2_valid;
    logic [3:0] out1_data, out2_data;
    logic       out1_src, out2_src;
    logic       out1_ready = 1'b0, out2_ready = 1'b0;
    logic       control;

    int checks = 0;
    int errors = 0;

    logic [5:0] model [$];

    crossbar_2x2_scheduler dut (
        .clk(clk), .rst(rst),
        .in1_valid(in1_valid), .in1_data(in1_data), .in1_dest(in1_dest), .in1_ready(in1_ready),
        .in2_valid(in2_valid), .in2_data(in2_data), .in2_dest(in2_dest), .in2_ready(in2_ready),
        .out1_valid(out1_valid), .out1_data(out1_data), .out1_src(out1_src), .out1_ready(out1_ready),
        .out2_valid(out2_valid), .out2_data(out2_data), .out2_src(out2_src), .out2_ready(out2_ready),
        .control(control)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Match an observed output word to the oldest pending word with the same source and destination.
    task automatic consume(input logic src, input logic dest, input logic [3:0] data);
        int  idx;
        idx = -1;
        for (int k = 0; k < model.size(); k++) begin
            if (idx < 0 && model[k][5:4] == {src, dest}) idx = k;
        end
        check("rnd_known_word", 16'(idx >= 0), 16'd1);
        if (idx >= 0) begin
            check("rnd_data", {12'd0, data}, {12'd0, model[idx][3:0]});
            model.delete(idx);
        end
    endtask

    task automatic rnd_cycle(input bit drive);
        if (drive) begin
            in1_valid  = 1'($urandom_range(0, 1));
            in1_data   = 4'($urandom);
            in1_dest   = 1'($urandom_range(0, 1));
            in2_valid  = 1'($urandom_range(0, 1));
            in2_data   = 4'($urandom);
            in2_dest   = 1'($urandom_range(0, 1));
            out1_ready = ($urandom_range(0, 3) != 0);
            out2_ready = ($urandom_range(0, 3) != 0);
        end else begin
            in1_valid  = 1'b0;
            in2_valid  = 1'b0;
            out1_ready = 1'b1;
            out2_ready = 1'b1;
        end
        #1;
        if (out1_valid && out1_ready) consume(out1_src, 1'b0, out1_data);
        if (out2_valid && out2_ready) consume(out2_src, 1'b1, out2_data);
        if (in1_valid && in1_ready) model.push_back({1'b0, in1_dest, in1_data});
        if (in2_valid && in2_ready) model.push_back({1'b1, in2_dest, in2_data});
        step();
    endtask

    initial begin
        logic [3:0] seq1 [4];
        logic [3:0] seq2 [4];
        logic [4:0] got [8];
        logic [4:0] exp_conf [6];
        int i1, i2, n_got;
        bit fire1, fire2;

        // Reset behaviour
        rst = 1'b1;
        step();
        step();
        check("rst_in1_ready", 16'(in1_ready), 16'd0);
        check("rst_in2_ready", 16'(in2_ready), 16'd0);
        check("rst_out_valid", {14'd0, out1_valid, out2_valid}, 16'd0);
        check("rst_out_data", {8'd0, out1_data, out2_data}, 16'd0);
        check("rst_src_ctrl", {13'd0, out1_src, out2_src, control}, 16'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", {14'd0, in1_ready, in2_ready}, 16'b11);

        // Parallel transfer
        out1_ready = 1'b1; out2_ready = 1'b1;
        in1_valid = 1'b1; in1_data = 4'h3; in1_dest = 1'b0;
        in2_valid = 1'b1; in2_data = 4'hA; in2_dest = 1'b1;
        step();
        in1_valid = 1'b0; in2_valid = 1'b0;
        check("par_latency", {14'd0, out1_valid, out2_valid}, 16'd0);
        step();
        check("par_out1", {11'd0, out1_valid, out1_data}, {11'd0, 1'b1, 4'h3});
        check("par_out2", {11'd0, out2_valid, out2_data}, {11'd0, 1'b1, 4'hA});
        check("par_src_ctrl", {13'd0, out1_src, out2_src, control}, 16'b010);
        step();
        check("par_drained", {14'd0, out1_valid, out2_valid}, 16'd0);

        // Cross transfer
        in1_valid = 1'b1; in1_data = 4'h5; in1_dest = 1'b1;
        in2_valid = 1'b1; in2_data = 4'hC; in2_dest = 1'b0;
        step();
        in1_valid = 1'b0; in2_valid = 1'b0;
        step();
        check("cross_out2", {10'd0, out2_valid, out2_src, out2_data}, {10'd0, 1'b1, 1'b0, 4'h5});
        check("cross_out1", {10'd0, out1_valid, out1_src, out1_data}, {10'd0, 1'b1, 1'b1, 4'hC});
        check("cross_ctrl", 16'(control), 16'd1);
        step();
        check("cross_drained", {14'd0, out1_valid, out2_valid}, 16'd0);
        check("ctrl_hold_idle", 16'(control), 16'd1);

        // Conflict: both inputs target out1
        seq1 = '{4'd1, 4'd2, 4'd3, 4'd0};
        seq2 = '{4'd9, 4'd8, 4'd7, 4'd0};
        exp_conf = '{{1'b0, 4'd1}, {1'b1, 4'd9}, {1'b0, 4'd2}, {1'b1, 4'd8}, {1'b0, 4'd3}, {1'b1, 4'd7}};
        for (int k = 0; k < 8; k++) got[k] = 5'h1F;
        i1 = 0; i2 = 0; n_got = 0;
        out1_ready = 1'b1;
        for (int cyc = 0; cyc < 30 && n_got < 6; cyc++) begin
            in1_valid = (i1 < 3); in1_data = seq1[i1]; in1_dest = 1'b0;
            in2_valid = (i2 < 3); in2_data = seq2[i2]; in2_dest = 1'b0;
            #1;
            fire1 = in1_valid && in1_ready;
            fire2 = in2_valid && in2_ready;
            if (out1_valid) begin
                got[n_got] = {out1_src, out1_data};
                n_got++;
            end
            step();
            if (fire1) i1++;
            if (fire2) i2++;
        end
        in1_valid = 1'b0; in2_valid = 1'b0;
        check("conf_count", 16'(n_got), 16'd6);
        for (int k = 0; k < 6; k++) check($sformatf("conf_word%0d", k), {11'd0, got[k]}, {11'd0, exp_conf[k]});
        step();

        // Backpressure on out1
        out1_ready = 1'b0;
        in1_valid = 1'b1; in1_dest = 1'b0; in1_data = 4'd4;
        step();
        in1_data = 4'd5;
        step();
        in1_data = 4'd6;
        step();
        in1_valid = 1'b0;
        check("bp_hold4", {11'd0, out1_valid, out1_data}, {11'd0, 1'b1, 4'd4});
        check("bp_in1_full", 16'(in1_ready), 16'd0);
        step();
        step();
        check("bp_stable", {10'd0, out1_valid, out1_src, out1_data}, {10'd0, 1'b1, 1'b0, 4'd4});
        out1_ready = 1'b1;
        step();
        check("bp_word5", {11'd0, out1_valid, out1_data}, {11'd0, 1'b1, 4'd5});
        check("bp_in1_ready", 16'(in1_ready), 16'd1);
        step();
        check("bp_word6", {11'd0, out1_valid, out1_data}, {11'd0, 1'b1, 4'd6});
        step();
        check("bp_drained", 16'(out1_valid), 16'd0);

        // Reset with full FIFOs and held outputs
        out1_ready = 1'b0; out2_ready = 1'b0;
        in1_valid = 1'b1; in1_data = 4'd1; in1_dest = 1'b0;
        in2_valid = 1'b1; in2_data = 4'd2; in2_dest = 1'b1;
        step();
        step();
        step();
        in1_valid = 1'b0; in2_valid = 1'b0;
        check("mid_full", {12'd0, in1_ready, in2_ready, out1_valid, out2_valid}, 16'b0011);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("mid_rst_valid", {14'd0, out1_valid, out2_valid}, 16'd0);
        check("mid_rst_ready", {14'd0, in1_ready, in2_ready}, 16'b11);
        out1_ready = 1'b1; out2_ready = 1'b1;
        in1_valid = 1'b1; in1_data = 4'hF; in1_dest = 1'b0;
        step();
        in1_valid = 1'b0;
        check("fresh_latency", {14'd0, out1_valid, out2_valid}, 16'd0);
        step();
        check("fresh_word", {10'd0, out1_valid, out1_src, out1_data}, {10'd0, 1'b1, 1'b0, 4'hF});
        check("no_stale_out2", 16'(out2_valid), 16'd0);
        step();

        // Random traffic against the reference queues
        model.delete();
        for (int cyc = 0; cyc < 400; cyc++) rnd_cycle(1'b1);
        for (int cyc = 0; cyc < 20; cyc++) rnd_cycle(1'b0);
        check("rnd_all_delivered", 16'(model.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
